// File: rtl/seg7_pkg.sv
// Shared glyph constants for the seven-segment scan driver.
// Segment order {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n (0..9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = SEG7_GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver stepped by an asynchronous tick.
// Optional leading-zero blanking: define SEG7_SCAN_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  in_clk,
  input  logic                  rst_n,
  input  logic                  tick_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic s1, s2, s3;
  logic step_c;
  logic [IDX_W-1:0] idx, next_idx_c;
  logic wrap_c;

  logic [4*DIGITS-1:0] frame_data;
  logic [DIGITS-1:0]   frame_dp, frame_en;
  logic [4*DIGITS-1:0] src_data_c;
  logic [DIGITS-1:0]   src_dp_c, src_en_c;
  logic [DIGITS-1:0]   keep_c;

  logic [3:0]          sel_nib_c;
  logic                sel_dp_c, sel_lit_c;
  logic [DIGITS-1:0]   an_next_c;
  logic [6:0]          glyph_c;

  // Tick synchroniser with history flop for rising-edge detection.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_c     = s2 & ~s3;
  assign wrap_c     = (idx == LAST_IDX);
  assign next_idx_c = wrap_c ? '0 : idx + IDX_W'(1);

  // Digit 0 displays the frame being captured on this same step.
  assign src_data_c = wrap_c ? data     : frame_data;
  assign src_dp_c   = wrap_c ? dp_in    : frame_dp;
  assign src_en_c   = wrap_c ? digit_en : frame_en;

`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
  // keep_c[k] is set when digit k or any digit above it is nonzero.
  always_comb begin
    logic acc;
    keep_c    = '0;
    acc       = 1'b0;
    keep_c[0] = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      acc       = acc | (|src_data_c[4*k +: 4]);
      keep_c[k] = acc;
    end
  end
`else
  assign keep_c = '1;
`endif

  always_comb begin
    sel_nib_c = '0;
    sel_dp_c  = 1'b0;
    sel_lit_c = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (next_idx_c == IDX_W'(k)) begin
        sel_nib_c = src_data_c[4*k +: 4];
        sel_dp_c  = src_dp_c[k];
        sel_lit_c = src_en_c[k] & keep_c[k];
      end
    end
  end

  always_comb begin
    an_next_c = '1;
    for (int k = 0; k < DIGITS; k++) begin
      an_next_c[k] = ~(sel_lit_c && (next_idx_c == IDX_W'(k)));
    end
  end

  hex_to_seg7 u_dec (
    .nibble (sel_nib_c),
    .seg_c  (glyph_c)
  );

  // Index, frame and outputs all update together on a step.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= LAST_IDX;
      frame_data <= '0;
      frame_dp   <= '0;
      frame_en   <= '0;
      an         <= '1;
      seg        <= SEG7_BLANK;
      dp         <= 1'b1;
    end else if (step_c) begin
      idx <= next_idx_c;
      if (wrap_c) begin
        frame_data <= data;
        frame_dp   <= dp_in;
        frame_en   <= digit_en;
      end
      an  <= an_next_c;
      seg <= sel_lit_c ? glyph_c : SEG7_BLANK;
      dp  <= sel_lit_c ? ~sel_dp_c : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a frame-level display model.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS = 4;

  logic        in_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_clk = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.DIGITS(DIGITS)) dut (
    .in_clk   (in_clk),
    .rst_n    (rst_n),
    .tick_clk (tick_clk),
    .data     (data),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 in_clk = ~in_clk;

  // Active-high glyphs {g,f,e,d,c,b,a}; the display is driven with the inverse.
  localparam logic [6:0] GLYPH_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int checks = 0;
  int errors = 0;

  int          m_idx;
  logic [15:0] m_fdata;
  logic [3:0]  m_fdp, m_fen;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_an"},  16'(an),  16'(e_an));
    check({tag, "_seg"}, 16'(seg), 16'(e_seg));
    check({tag, "_dp"},  16'(dp),  16'(e_dp));
  endtask

  function automatic void model_reset();
    m_idx   = DIGITS - 1;
    m_fdata = '0;
    m_fdp   = '0;
    m_fen   = '0;
    e_an    = '1;
    e_seg   = 7'h7F;
    e_dp    = 1'b1;
  endfunction

  // One display step: move to the next digit, grab a new frame when starting over.
  function automatic void model_step();
    logic lit;
    int   nib;
    m_idx = (m_idx + 1) % DIGITS;
    if (m_idx == 0) begin
      m_fdata = data;
      m_fdp   = dp_in;
      m_fen   = digit_en;
    end
    nib = int'((m_fdata >> (4 * m_idx)) & 16'hF);
    lit = m_fen[m_idx];
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    if (m_idx != 0 && (m_fdata >> (4 * m_idx)) == 16'h0) lit = 1'b0;
`endif
    e_an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e_seg = lit ? ~GLYPH_ON[nib] : 7'h7F;
    e_dp  = lit ? ~m_fdp[m_idx] : 1'b1;
  endfunction

  // One tick: outputs must hold for two edges and change on the third.
  task automatic do_tick(input string tag);
    @(posedge in_clk);
    #3 tick_clk = 1'b1;
    @(posedge in_clk);
    @(posedge in_clk);
    #1 check({tag, "_hold"}, 16'({an, seg, dp}), 16'({e_an, e_seg, e_dp}));
    @(posedge in_clk);
    #1 model_step();
    check_out(tag);
    #1 tick_clk = 1'b0;
    repeat (3) @(posedge in_clk);
  endtask

  initial begin
    int       changes;
    int       first_cyc;
    logic [3:0] prev_an;

    model_reset();

    // Reset held with tick toggling: outputs blank throughout.
    repeat (6) begin
      @(posedge in_clk);
      #2 tick_clk = ~tick_clk;
      #1 check_out("rst_hold");
    end
    tick_clk = 1'b0;
    repeat (3) @(posedge in_clk);
    #3 rst_n = 1'b1;
    repeat (4) begin
      repeat (5) @(posedge in_clk);
      #1 check_out("post_rst_idle");
    end

    // Basic scan of 12AF with one decimal point, two full frames.
    data = 16'h12AF; dp_in = 4'b0100; digit_en = 4'hF;
    do_tick("scan_first");
    check("scan_first_glyph_F", 16'(seg), 16'(7'h0E));
    check("scan_first_an", 16'(an), 16'(4'b1110));
    for (int i = 0; i < 7; i++) do_tick("scan");

    // Single rise held high for 1000 cycles gives exactly one step, on edge 3.
    data = 16'h4321; dp_in = 4'h0;
    for (int i = 0; i < 4; i++) do_tick("lat_prep");
    @(posedge in_clk);
    #3 tick_clk = 1'b1;
    changes   = 0;
    first_cyc = 0;
    prev_an   = an;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge in_clk);
      #1;
      if (an !== prev_an) begin
        changes++;
        if (first_cyc == 0) first_cyc = c;
      end
      prev_an = an;
    end
    model_step();
    check("lat_changes", 16'(changes), 16'd1);
    check("lat_edge", 16'(first_cyc), 16'd3);
    check_out("lat_final");
    tick_clk = 1'b0;
    repeat (4) @(posedge in_clk);

    // Tear-free: data change after digit 1 is shown waits for the next frame.
    data = 16'h1111;
    for (int i = 0; i < DIGITS && m_idx != 3; i++) do_tick("tear_align");
    do_tick("tear_d0");
    do_tick("tear_d1");
    data = 16'h2222;
    do_tick("tear_d2");
    check("tear_d2_old", 16'(seg), 16'(7'h79));
    do_tick("tear_d3");
    check("tear_d3_old", 16'(seg), 16'(7'h79));
    for (int i = 0; i < 4; i++) begin
      do_tick("tear_new");
      check("tear_new_glyph", 16'(seg), 16'(7'h24));
    end

    // Per-digit blanking via digit_en.
    data = 16'h8888; digit_en = 4'b0101; dp_in = 4'hF;
    for (int i = 0; i < 8; i++) do_tick("blank_en");

    // Leading-zero frames (blanked only when the option is built in).
    digit_en = 4'hF; dp_in = 4'h0;
    data = 16'h0005;
    for (int i = 0; i < 8; i++) do_tick("lz_0005");
    data = 16'h0000;
    for (int i = 0; i < 8; i++) do_tick("lz_0000");

    // Randomised inputs, updated occasionally between ticks.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        data     = 16'($urandom) >> (4 * $urandom_range(0, 3));
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
      end
      do_tick("rand");
    end

    // Mid-frame reset at idx 2: immediate blanking, fresh frame afterwards.
    data = 16'h9999; digit_en = 4'hF;
    for (int i = 0; i < DIGITS && m_idx != 2; i++) do_tick("mid_align");
    check("mid_idx_reached", 16'(m_idx), 16'd2);
    @(posedge in_clk);
    #4 rst_n = 1'b0;
    #1 model_reset();
    check_out("mid_rst_now");
    repeat (3) @(posedge in_clk);
    #3 rst_n = 1'b1;
    data = 16'h7773; dp_in = 4'b0001; digit_en = 4'hF;
    repeat (5) @(posedge in_clk);
    #1 check_out("mid_rst_idle");
    do_tick("mid_first");
    check("mid_first_an", 16'(an), 16'(4'b1110));
    check("mid_first_seg", 16'(seg), 16'(7'h30));
    check("mid_first_dp", 16'(dp), 16'd0);
    for (int i = 0; i < 3; i++) do_tick("mid_rest");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
